mfp_ahb_uart_tx: RTL and testbench
==================================

Name: mfp_ahb_uart_tx

Overview:
- AHB-lite slave on the MFP system bus: a memory-mapped UART transmitter for debug and telemetry output from software.
- Occupies one HSEL slot from the address decoder. Receives the same address/data-phase signals as the GPIO slave. Read data is returned through the bus read mux in the data phase.
- Contains a byte TX FIFO, a programmable baud divider and an 8N1 serializer. A level interrupt signals when the transmitter is empty.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..256.
- DIV_W, 16, baud divider width in bits.
- DEFAULT_DIV, 434, reset value of BAUDDIV in HCLK cycles per bit (50 MHz / 115200).

Ports:
- HCLK  in  1  bus clock; all state on its rising edge.
- HRESETn  in  1  reset, asynchronous assert, active-low.
- HADDR  in  4  word offset, bus HADDR[5:2].
- HTRANS  in  2  AHB transfer type; HTRANS[1]=1 means an active transfer.
- HWDATA  in  32  write data, valid in the data phase.
- HWRITE  in  1  write strobe, address phase.
- HSEL  in  1  slave select from the decoder, address phase.
- HRDATA  out  32  read data, registered, valid in the data phase.
- UART_TX  out  1  serial output; idles high.
- TX_IRQ  out  1  level interrupt.

Behaviour:
- Clock/reset: one clock HCLK. HRESETn is asynchronous, active-low.
- Reset values:
  - HRDATA=0, UART_TX=1, TX_IRQ=0.
  - FIFO empty, count=0, overflow=0.
  - BAUDDIV=DEFAULT_DIV, IRQ_EN=0, TX_EN=1, state IDLE.
- Zero wait states: the bus ties HREADY=1.
- Address phase accepted when HSEL & HTRANS[1]. HADDR and HWRITE are captured into registers at that edge.
- Write takes effect at the edge ending the data phase, using HWDATA.
- Read data is registered at the edge ending the address phase, so HRDATA is valid throughout the data phase.
- Unselected cycles leave HRDATA unchanged.
- Register map (word offsets):
  - 0x0 TXDATA, W: push HWDATA[7:0]. Read returns 0.
  - 0x1 STATUS, R: {23'b0, overflow[8], busy[7], full[6], empty[5], count[4:0]}; count saturates at 31 in the field. W: HWDATA[8]=1 clears overflow.
  - 0x2 BAUDDIV, R/W: [DIV_W-1:0]. A written 0 or 1 is stored as 2.
  - 0x3 CTRL, R/W: bit0 IRQ_EN, bit1 TX_EN.
  - Other offsets: reads 0, writes ignored.
- FIFO:
  - Push when full: the byte is dropped and overflow is set (sticky).
  - Push and pop in the same cycle: count unchanged, both take effect.
  - Full means count==FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- Serializer FSM: IDLE, START, DATA, STOP.
  - IDLE to START when !empty & TX_EN. In the same edge: pop the byte into the shift register, latch BAUDDIV into the bit timer, drive UART_TX=0.
  - Each state holds for the latched BAUDDIV cycles.
  - DATA sends 8 bits LSB first, with a 3-bit index.
  - STOP drives 1. From STOP go to START if !empty & TX_EN, otherwise IDLE; back-to-back frames have no idle gap.
  - UART_TX is driven from a flop; no combinational path.
- busy = (state != IDLE).
- TX_IRQ = IRQ_EN & empty & !busy, registered (one cycle of lag).
- Latency: a TXDATA write whose data phase ends at edge E0 makes count=1 at E0. START begins at E0+1 with UART_TX low.
- BAUDDIV or TX_EN written mid-frame: the current frame completes unchanged. TX_EN=0 only blocks new frames.
- Reset mid-frame: UART_TX returns to 1 immediately and asynchronously. Pending bytes are discarded.

Test Plan:
- BAUDDIV=4, write TXDATA=0x55 → UART_TX low for 4 cycles starting E0+1. Then bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop high 4 cycles. STATUS then reads 0x020.
- TX_EN=0, write 17 bytes 0x00..0x10 → STATUS=0x150 (overflow, full, count 16). Write STATUS bit8 → 0x050. Set TX_EN=1 → bytes 0x00..0x0F transmitted back-to-back with no idle gap.
- Read BAUDDIV right after reset → 434. Write 0 → reads 2. Write 0x1234 → reads 0x1234 with HRDATA valid in the data-phase cycle.
- IRQ_EN=1, write one byte → TX_IRQ drops, then rises exactly one cycle after state returns to IDLE with the FIFO empty.
- Write BAUDDIV=8 during the DATA state of a BAUDDIV=4 frame → that frame finishes at 4 cycles/bit, the next frame runs at 8 cycles/bit.
- Assert HRESETn=0 mid-bit → UART_TX=1 with no clock edge needed. After release, STATUS=0x020 and no frame starts.

Source files
------------

// File: rtl/mfp_ahb_uart_tx.sv
// AHB-lite UART transmitter: byte TX FIFO, programmable baud divider and 8N1 serializer.
// Transmitter-empty level interrupt, zero-wait-state register interface.
module mfp_ahb_uart_tx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [3:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic        HSEL,
  output logic [31:0] HRDATA,
  output logic        UART_TX,
  output logic        TX_IRQ
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // A divider below 2 cannot produce a valid bit period.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [31:0] d);
    logic [DIV_W-1:0] v;
    v = d[DIV_W-1:0];
    return (v < DIV_W'(2)) ? DIV_W'(2) : v;
  endfunction

  function automatic logic [4:0] sat_count(input logic [CW-1:0] c);
    logic [31:0] cx;
    cx = 32'(c);
    return (cx > 32'd31) ? 5'd31 : cx[4:0];
  endfunction

  logic              addr_vld_p0;
  logic              wr_vld_p1;
  logic [3:0]        wr_addr_p1;
  logic              wr_txdata, wr_status, wr_baud, wr_ctrl;
  logic [DIV_W-1:0]  baud_div;
  logic              irq_en, tx_en, overflow;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              empty, full, push_ok, pop, busy, start_ok, bit_done;
  logic [31:0]       rd_mux;
  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_lat, div_nxt, timer, timer_nxt;
  logic [2:0]        idx, idx_nxt;
  logic [7:0]        shreg, sh_nxt;
  logic              tx_nxt;
  logic              unused_bits;

  assign unused_bits = &{1'b0, HTRANS[0], HWDATA[31:9]};

  assign addr_vld_p0 = HSEL & HTRANS[1];

  // Address phase -> data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_vld_p1  <= 1'b0;
      wr_addr_p1 <= 4'd0;
    end else begin
      wr_vld_p1  <= addr_vld_p0 & HWRITE;
      wr_addr_p1 <= HADDR;
    end
  end

  assign wr_txdata = wr_vld_p1 && (wr_addr_p1 == 4'h0);
  assign wr_status = wr_vld_p1 && (wr_addr_p1 == 4'h1);
  assign wr_baud   = wr_vld_p1 && (wr_addr_p1 == 4'h2);
  assign wr_ctrl   = wr_vld_p1 && (wr_addr_p1 == 4'h3);

  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign push_ok  = wr_txdata & ~full;
  assign busy     = (state != IDLE);
  assign start_ok = ~empty & tx_en;
  assign bit_done = (timer == div_lat - 1'b1);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      baud_div <= DIV_W'(DEFAULT_DIV);
      irq_en   <= 1'b0;
      tx_en    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_baud) baud_div <= clamp_div(HWDATA);
      if (wr_ctrl) begin
        irq_en <= HWDATA[0];
        tx_en  <= HWDATA[1];
      end
      if (wr_txdata && full)           overflow <= 1'b1;
      else if (wr_status && HWDATA[8]) overflow <= 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push_ok) mem[wr_ptr] <= HWDATA[7:0];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (HADDR)
      4'h1:    rd_mux = {23'd0, overflow, busy, full, empty, sat_count(count)};
      4'h2:    rd_mux = 32'(baud_div);
      4'h3:    rd_mux = {30'd0, tx_en, irq_en};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                  HRDATA <= 32'd0;
    else if (addr_vld_p0 & ~HWRITE) HRDATA <= rd_mux;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_ok) state_nxt = START;
      START: if (bit_done) state_nxt = DATA;
      DATA:  if (bit_done && idx == 3'd7) state_nxt = STOP;
      STOP:  if (bit_done) state_nxt = start_ok ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A new frame loads from IDLE or directly out of STOP so frames run back-to-back.
  always_comb begin
    pop       = ((state == IDLE) || (state == STOP && bit_done)) && start_ok;
    timer_nxt = ((state == IDLE) || bit_done) ? '0 : timer + 1'b1;
    div_nxt   = pop ? baud_div : div_lat;
    idx_nxt   = idx;
    sh_nxt    = shreg;
    if (pop) begin
      sh_nxt  = mem[rd_ptr];
      idx_nxt = 3'd0;
    end else if (state == DATA && bit_done) begin
      sh_nxt  = shreg >> 1;
      idx_nxt = idx + 1'b1;
    end
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = sh_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      timer   <= '0;
      idx     <= 3'd0;
      UART_TX <= 1'b1;
      TX_IRQ  <= 1'b0;
    end else begin
      timer   <= timer_nxt;
      idx     <= idx_nxt;
      UART_TX <= tx_nxt;
      TX_IRQ  <= irq_en & empty & ~busy;
    end
  end

  always_ff @(posedge HCLK) begin
    div_lat <= div_nxt;
    shreg   <= sh_nxt;
  end

endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// Self-checking bench for mfp_ahb_uart_tx: register vector table, UART frame scoreboard,
// and directed sequences for overflow, back-to-back frames, IRQ timing, divider change and reset.
module tb_mfp_ahb_uart_tx;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [3:0]  HADDR = 4'd0;
  logic [1:0]  HTRANS = 2'd0;
  logic [31:0] HWDATA = 32'd0;
  logic        HWRITE = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HRDATA;
  logic        UART_TX;
  logic        TX_IRQ;

  mfp_ahb_uart_tx #(.FIFO_DEPTH(16), .DIV_W(16), .DEFAULT_DIV(434)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HSEL(HSEL), .HRDATA(HRDATA), .UART_TX(UART_TX), .TX_IRQ(TX_IRQ)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] b;
    int         div;
  } frame_t;

  typedef struct {
    bit          wr;
    logic [3:0]  a;
    logic [31:0] d;
  } vec_t;

  frame_t sb_q[$];
  int     start_cyc[$];
  int     frames_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // UART line monitor: decodes each frame and compares every sample against the scoreboard.
  initial begin
    forever begin
      frame_t     f;
      logic [9:0] pat;
      bit         ok;
      bit         aborted;
      int         bad_i;
      logic       bad_v;
      @(negedge HCLK);
      if (HRESETn && UART_TX === 1'b0) begin
        start_cyc.push_back(cyc);
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame: start at cycle %0d, expected no frame", cyc);
          f.b = 8'h00;
          f.div = 4;
        end else begin
          f = sb_q.pop_front();
        end
        pat = {1'b1, f.b, 1'b0};
        ok = 1'b1;
        aborted = 1'b0;
        bad_i = 0;
        bad_v = 1'b0;
        for (int i = 0; i < 10 * f.div; i++) begin
          if (i > 0) @(negedge HCLK);
          if (!HRESETn) begin
            aborted = 1'b1;
            break;
          end
          if (ok && UART_TX !== pat[i / f.div]) begin
            ok = 1'b0;
            bad_i = i;
            bad_v = UART_TX;
          end
        end
        if (!aborted) begin
          n_tests++;
          if (!ok) begin
            n_fail++;
            $display("FAIL frame_0x%02h: sample %0d got %b, expected %b",
                     f.b, bad_i, bad_v, pat[bad_i / f.div]);
          end
          frames_done++;
        end
      end
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(posedge HCLK); #1;
    HWDATA = 32'd0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t;
    t = 0;
    while (frames_done < n && t < budget) begin
      @(posedge HCLK); #1;
      t++;
    end
    check("frames_done", frames_done, n);
  endtask

  localparam int NV = 21;
  vec_t vt [NV];

  initial begin
    logic [31:0] r;
    int e0;
    int bad;

    vt[0]  = '{1'b0, 4'h2, 32'd434};
    vt[1]  = '{1'b1, 4'h2, 32'd0};
    vt[2]  = '{1'b0, 4'h2, 32'd2};
    vt[3]  = '{1'b1, 4'h2, 32'd1};
    vt[4]  = '{1'b0, 4'h2, 32'd2};
    vt[5]  = '{1'b1, 4'h2, 32'h1234};
    vt[6]  = '{1'b0, 4'h2, 32'h1234};
    vt[7]  = '{1'b0, 4'h0, 32'h0};
    vt[8]  = '{1'b0, 4'h3, 32'h2};
    vt[9]  = '{1'b0, 4'h1, 32'h020};
    vt[10] = '{1'b1, 4'h5, 32'hFFFF};
    vt[11] = '{1'b0, 4'h5, 32'h0};
    vt[12] = '{1'b0, 4'h2, 32'h1234};
    vt[13] = '{1'b1, 4'h3, 32'h3};
    vt[14] = '{1'b0, 4'h3, 32'h3};
    vt[15] = '{1'b1, 4'h3, 32'h2};
    vt[16] = '{1'b0, 4'h3, 32'h2};
    vt[17] = '{1'b1, 4'h2, 32'h12345};
    vt[18] = '{1'b0, 4'h2, 32'h2345};
    vt[19] = '{1'b1, 4'h2, 32'd4};
    vt[20] = '{1'b0, 4'h2, 32'd4};

    repeat (3) @(posedge HCLK);
    #1;
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_uart_tx", 32'(UART_TX), 32'd1);
    check("rst_tx_irq", 32'(TX_IRQ), 32'd0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    for (int i = 0; i < NV; i++) begin
      if (vt[i].wr) begin
        bus_write(vt[i].a, vt[i].d);
      end else begin
        bus_read(vt[i].a, r);
        check($sformatf("reg_vec_%0d", i), r, vt[i].d);
      end
    end

    HSEL = 1'b0; HTRANS = 2'b10; HADDR = 4'h1;
    repeat (2) @(posedge HCLK);
    #1;
    HTRANS = 2'b00;
    check("hrdata_hold_unsel", HRDATA, 32'd4);

    // Single 0x55 frame at 4 cycles/bit
    start_cyc.delete();
    frames_done = 0;
    sb_q.push_back('{8'h55, 4});
    bus_write(4'h0, 32'h55);
    e0 = cyc;
    check("tx_high_at_e0", 32'(UART_TX), 32'd1);
    wait_frames(1, 100);
    check("start_latency", (start_cyc.size() > 0) ? start_cyc[0] : -1, e0 + 1);
    bus_read(4'h1, r);
    check("status_after_frame", r, 32'h020);

    // Overflow with TX disabled, then back-to-back drain
    bus_write(4'h3, 32'h0);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) sb_q.push_back('{8'(i), 4});
      bus_write(4'h0, 32'(i));
    end
    bus_read(4'h1, r);
    check("status_overflow_full", r, 32'h150);
    bus_write(4'h1, 32'h100);
    bus_read(4'h1, r);
    check("status_ovf_cleared", r, 32'h050);
    start_cyc.delete();
    frames_done = 0;
    bus_write(4'h3, 32'h2);
    wait_frames(16, 16 * 40 + 100);
    check("b2b_frame_count", start_cyc.size(), 16);
    bad = 0;
    for (int k = 1; k < start_cyc.size(); k++)
      if (start_cyc[k] - start_cyc[k-1] != 40) bad++;
    check("b2b_gaps_bad", bad, 0);
    bus_read(4'h1, r);
    check("status_drained", r, 32'h020);

    // IRQ timing around one frame
    bus_write(4'h3, 32'h3);
    @(posedge HCLK); #1;
    check("irq_high_idle", 32'(TX_IRQ), 32'd1);
    frames_done = 0;
    sb_q.push_back('{8'hC3, 4});
    bus_write(4'h0, 32'hC3);
    bad = 0;
    for (int k = 0; k <= 42; k++) begin
      if (k > 0) begin
        @(posedge HCLK); #1;
      end
      if (TX_IRQ !== ((k == 0) || (k == 42))) begin
        if (bad == 0) $display("FAIL irq_timing: cycle E0+%0d got %b", k, TX_IRQ);
        bad++;
      end
    end
    check("irq_timing_bad_cycles", bad, 0);
    check("irq_frame_done", frames_done, 1);
    bus_write(4'h3, 32'h2);

    // Divider change mid-frame
    start_cyc.delete();
    frames_done = 0;
    sb_q.push_back('{8'h3C, 4});
    bus_write(4'h0, 32'h3C);
    repeat (8) @(posedge HCLK);
    #1;
    bus_write(4'h2, 32'd8);
    sb_q.push_back('{8'h81, 8});
    bus_write(4'h0, 32'h81);
    wait_frames(2, 300);
    check("div_change_gap", (start_cyc.size() > 1) ? start_cyc[1] - start_cyc[0] : -1, 40);
    bus_write(4'h2, 32'd4);

    // Reset mid-bit
    sb_q.push_back('{8'hA5, 4});
    bus_write(4'h0, 32'hA5);
    bus_write(4'h0, 32'h77);
    repeat (8) @(posedge HCLK);
    #1;
    check("pre_reset_tx_low", 32'(UART_TX), 32'd0);
    #2;
    HRESETn = 1'b0;
    #1;
    check("async_reset_tx_high", 32'(UART_TX), 32'd1);
    check("async_reset_hrdata", HRDATA, 32'd0);
    repeat (3) @(posedge HCLK);
    #3;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    bus_read(4'h1, r);
    check("status_after_reset", r, 32'h020);
    bus_read(4'h2, r);
    check("baud_after_reset", r, 32'd434);
    bad = 0;
    repeat (30) begin
      @(posedge HCLK); #1;
      if (UART_TX !== 1'b1) bad++;
    end
    check("no_frame_after_reset", bad, 0);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
